// File: rtl/ex_mem_skid.sv
// EX/MEM boundary register with a one-entry skid buffer behind the main entry.
// The main entry drives MEM and the EX forwarding path; the skid entry absorbs one MEM stall.
module ex_mem_skid #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FUNCT3_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,

  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_ALUResult,
  input  logic [DATA_WIDTH-1:0]     in_StoreData,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [FUNCT3_WIDTH-1:0]   in_Funct3,
  input  logic                      in_RegWrite,
  input  logic                      in_MemRead,
  input  logic                      in_MemWrite,
  input  logic                      in_MemToReg,

  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_ALUResult,
  output logic [DATA_WIDTH-1:0]     out_StoreData,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [FUNCT3_WIDTH-1:0]   out_Funct3,
  output logic                      out_RegWrite,
  output logic                      out_MemRead,
  output logic                      out_MemWrite,
  output logic                      out_MemToReg,

  output logic [1:0]                occupancy,

  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [FUNCT3_WIDTH-1:0]   funct3;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
  } entry_t;

  state_t state, state_next;
  entry_t main_q, skid_q, in_entry;
  logic   in_accept, out_accept;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_entry = '{
    alu_result: in_ALUResult,
    store_data: in_StoreData,
    rd:         in_rd,
    funct3:     in_Funct3,
    reg_write:  in_RegWrite,
    mem_read:   in_MemRead,
    mem_write:  in_MemWrite,
    mem_to_reg: in_MemToReg
  };

  // Handshake flags come from registered state only, so in_ready never sees out_ready.
  assign in_ready   = (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_accept && out_accept) begin
            load_main_in = 1'b1;
          end else if (in_accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (out_accept) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_accept) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Payload only moves on an accepted transfer; flush leaves stale contents in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign occupancy     = state;
  assign out_ALUResult = main_q.alu_result;
  assign out_StoreData = main_q.store_data;
  assign out_rd        = main_q.rd;
  assign out_Funct3    = main_q.funct3;
  assign out_RegWrite  = main_q.reg_write;
  assign out_MemRead   = main_q.mem_read;
  assign out_MemWrite  = main_q.mem_write;
  assign out_MemToReg  = main_q.mem_to_reg;

  assign fwd_valid = out_valid && main_q.reg_write && (main_q.rd != '0);
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu_result;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed-vector bench for ex_mem_skid: streaming, skid backpressure, flush,
// x0 forwarding suppression and asynchronous reset in the middle of a stall.
module tb_ex_mem_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ALUResult;
  logic [31:0] in_StoreData;
  logic [4:0]  in_rd;
  logic [2:0]  in_Funct3;
  logic        in_RegWrite, in_MemRead, in_MemWrite, in_MemToReg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ALUResult;
  logic [31:0] out_StoreData;
  logic [4:0]  out_rd;
  logic [2:0]  out_Funct3;
  logic        out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg;
  logic [1:0]  occupancy;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int compared;
  int mismatched;

  ex_mem_skid dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ALUResult (in_ALUResult),
    .in_StoreData (in_StoreData),
    .in_rd        (in_rd),
    .in_Funct3    (in_Funct3),
    .in_RegWrite  (in_RegWrite),
    .in_MemRead   (in_MemRead),
    .in_MemWrite  (in_MemWrite),
    .in_MemToReg  (in_MemToReg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ALUResult(out_ALUResult),
    .out_StoreData(out_StoreData),
    .out_rd       (out_rd),
    .out_Funct3   (out_Funct3),
    .out_RegWrite (out_RegWrite),
    .out_MemRead  (out_MemRead),
    .out_MemWrite (out_MemWrite),
    .out_MemToReg (out_MemToReg),
    .occupancy    (occupancy),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // ctrl packs {RegWrite, MemRead, MemWrite, MemToReg}
  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input logic [2:0] f3, input logic [3:0] ctrl,
                               input logic ordy, input logic fl);
    in_valid     = v;
    in_ALUResult = alu;
    in_StoreData = sd;
    in_rd        = rd;
    in_Funct3    = f3;
    {in_RegWrite, in_MemRead, in_MemWrite, in_MemToReg} = ctrl;
    out_ready    = ordy;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b0, 1'b0);

    // Reset held for three cycles, then released
    repeat (3) step();
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_occupancy", {30'b0, occupancy}, 32'd0);
    reset = 1'b1;
    step();
    checkOutput("idle_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("idle_occupancy", {30'b0, occupancy}, 32'd0);
    checkOutput("idle_alu", out_ALUResult, 32'h0);
    checkOutput("idle_fwd_valid", {31'b0, fwd_valid}, 32'd0);

    // Streaming at one instruction per cycle
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'h10 * i, 32'h100 + i, 5'(i), 3'(i), 4'b1001, 1'b1, 1'b0);
      step();
      checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stream_alu", out_ALUResult, 32'h10 * i);
      checkOutput("stream_store", out_StoreData, 32'h100 + i);
      checkOutput("stream_rd", {27'b0, out_rd}, i);
      checkOutput("stream_funct3", {29'b0, out_Funct3}, i);
      checkOutput("stream_ctrl", {28'b0, out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg}, 32'b1001);
      checkOutput("stream_occ", {30'b0, occupancy}, 32'd1);
      checkOutput("stream_in_ready", {31'b0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("stream_drain_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("stream_drain_occ", {30'b0, occupancy}, 32'd0);

    // Backpressure fills the skid entry
    applyStimulus(1'b1, 32'hA, 32'hAA, 5'd5, 3'd2, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("bp_one_occ", {30'b0, occupancy}, 32'd1);
    applyStimulus(1'b1, 32'hB, 32'hBB, 5'd6, 3'd4, 4'b0110, 1'b0, 1'b0);
    step();
    checkOutput("bp_full_occ", {30'b0, occupancy}, 32'd2);
    checkOutput("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_full_alu", out_ALUResult, 32'hA);
    checkOutput("bp_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    checkOutput("bp_fwd_rd", {27'b0, fwd_rd}, 32'd5);
    checkOutput("bp_fwd_data", fwd_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 32'hCC, 5'd7, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("bp_hold_alu", out_ALUResult, 32'hA);
    checkOutput("bp_hold_occ", {30'b0, occupancy}, 32'd2);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("bp_skid_alu", out_ALUResult, 32'hB);
    checkOutput("bp_skid_store", out_StoreData, 32'hBB);
    checkOutput("bp_skid_rd", {27'b0, out_rd}, 32'd6);
    checkOutput("bp_skid_ctrl", {28'b0, out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg}, 32'b0110);
    checkOutput("bp_skid_occ", {30'b0, occupancy}, 32'd1);
    checkOutput("bp_skid_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_skid_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    step();
    checkOutput("bp_empty_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_empty_occ", {30'b0, occupancy}, 32'd0);

    // Flush while FULL, with EX still presenting 0x3
    applyStimulus(1'b1, 32'h1, 32'h0, 5'd1, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h2, 32'h0, 5'd2, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("fl_full_occ", {30'b0, occupancy}, 32'd2);
    applyStimulus(1'b1, 32'h3, 32'h0, 5'd3, 3'd0, 4'b1000, 1'b0, 1'b1);
    step();
    checkOutput("fl_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("fl_occ", {30'b0, occupancy}, 32'd0);
    checkOutput("fl_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("fl_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    checkOutput("fl_payload_held", out_ALUResult, 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("fl_after_valid", {31'b0, out_valid}, 32'd0);

    // Flush in ONE discards the same-cycle input accept
    applyStimulus(1'b1, 32'h7, 32'h0, 5'd8, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h3, 32'h0, 5'd3, 3'd0, 4'b1000, 1'b1, 1'b1);
    step();
    checkOutput("fl1_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("fl1_payload_held", out_ALUResult, 32'h7);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b1, 1'b0);
    step();
    checkOutput("fl1_after_occ", {30'b0, occupancy}, 32'd0);

    // Writes to x0 never forward
    applyStimulus(1'b1, 32'hDEAD, 32'h0, 5'd0, 3'd0, 4'b1000, 1'b1, 1'b0);
    step();
    checkOutput("x0_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("x0_alu", out_ALUResult, 32'hDEAD);
    checkOutput("x0_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    applyStimulus(1'b1, 32'hBEEF, 32'h0, 5'd9, 3'd0, 4'b0100, 1'b1, 1'b0);
    step();
    checkOutput("norw_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    applyStimulus(1'b1, 32'hCAFE, 32'h0, 5'd31, 3'd0, 4'b1000, 1'b1, 1'b0);
    step();
    checkOutput("rw31_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    checkOutput("rw31_fwd_rd", {27'b0, fwd_rd}, 32'd31);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b1, 1'b0);
    step();

    // Asynchronous reset between clock edges while FULL
    applyStimulus(1'b1, 32'h11, 32'h0, 5'd1, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h22, 32'h0, 5'd2, 3'd0, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("ar_full_occ", {30'b0, occupancy}, 32'd2);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("ar_occ", {30'b0, occupancy}, 32'd0);
    checkOutput("ar_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("ar_alu", out_ALUResult, 32'h0);
    step();
    #2;
    reset = 1'b1;
    step();
    checkOutput("ar_release_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1'b1, 32'h55, 32'h0, 5'd3, 3'd0, 4'b1000, 1'b1, 1'b0);
    step();
    checkOutput("ar_new_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("ar_new_alu", out_ALUResult, 32'h55);
    checkOutput("ar_new_occ", {30'b0, occupancy}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- EX/MEM boundary stage directly downstream of the ALU.
- Captures the ALU result plus memory/writeback control for one instruction, and presents it to the MEM stage over a valid/ready handshake.
- Holds a 2-entry (main + skid) buffer, so a MEM-side stall never drops an instruction already accepted from EX.
- Drives the EX forwarding source (fwd_*) from its output entry.

Parameters:
- DATA_WIDTH, 32, width of ALU result and store data.
- REG_ADDR_WIDTH, 5, destination register index width.
- FUNCT3_WIDTH, 3, width of funct3 carried for load/store sizing.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- flush  input  1  synchronous kill of all buffered entries (branch mispredict/trap).
- in_valid  input  1  EX presents an instruction.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_ALUResult  input  DATA_WIDTH  ALU result (address or value).
- in_StoreData  input  DATA_WIDTH  rs2 value for stores.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- in_Funct3  input  FUNCT3_WIDTH  access size/sign.
- in_RegWrite, in_MemRead, in_MemWrite, in_MemToReg  input  1 each  control bits.
- out_valid  output  1  main entry valid.
- out_ready  input  1  MEM stage accepts.
- out_ALUResult, out_StoreData, out_rd, out_Funct3, out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg  output  widths as inputs  main-entry payload.
- occupancy  output  2  entries held: 0, 1 or 2.
- fwd_valid  output  1  out_valid AND out_RegWrite AND out_rd != 0.
- fwd_rd  output  REG_ADDR_WIDTH  equals out_rd.
- fwd_data  output  DATA_WIDTH  equals out_ALUResult.

Behaviour:
- Handshake events:
  - Input accept: in_valid AND in_ready.
  - Output accept: out_valid AND out_ready.
  - Payload is sampled only on accept.
- Storage: main register drives all out_* ports; skid register is internal. No combinational path from in_* to out_*. in_ready depends only on registered state, never on out_ready.
- FSM states:
  - EMPTY (occ 0).
  - ONE (occ 1, main valid).
  - FULL (occ 2, main + skid valid).
- Transitions when flush = 0:
  - EMPTY: input accept -> ONE, main <- in. Otherwise stay.
  - ONE, input accept and output accept -> ONE, main <- in (back-to-back, 1 instr/cycle).
  - ONE, input accept only -> FULL, skid <- in.
  - ONE, output accept only -> EMPTY.
  - ONE, neither -> hold.
  - FULL: in_ready = 0. Output accept -> ONE, main <- skid. Otherwise hold both.
- Latency: 1 cycle from input accept (EMPTY) to out_valid. Steady-state throughput is 1 per cycle.
- Ordering: strict FIFO; the skid entry always leaves after main.
- flush = 1 (highest priority, clock edge):
  - Next state EMPTY.
  - Any input accept in that same cycle is discarded.
  - An output accept in that same cycle still counts as consumed by MEM.
  - Payload registers keep their values.
- Payload while out_valid = 0: holds last value. Consumers must ignore it; fwd_valid is forced 0.
- occupancy mirrors the state encoding 0/1/2. It is registered.
- Reset (reset = 0, asynchronous, any time including mid-transfer):
  - State EMPTY; out_valid = 0; occupancy = 0; in_ready = 1; fwd_valid = 0.
  - All payload registers = 0.
  - Release is sampled synchronously at the first rising edge with reset = 1.
- rd = 0 never asserts fwd_valid, even if RegWrite = 1.
- Simultaneous input accept and output accept in FULL cannot occur, because in_ready = 0 in FULL.

Test Plan:
- Reset then idle: reset = 0 for 3 cycles, release -> out_valid = 0, in_ready = 1, occupancy = 0, out_ALUResult = 0.
- Streaming: out_ready = 1, in_valid = 1 for 4 cycles with ALUResult 0x10, 0x20, 0x30, 0x40 and rd 1..4 -> each appears 1 cycle later in order; occupancy stays 1; in_ready stays 1.
- Backpressure/skid:
  - Stimulus: out_ready = 0, send 0xA (rd 5, RegWrite 1), then 0xB.
  - Response: occupancy 2, in_ready = 0, out_ALUResult = 0xA held, fwd_valid = 1 with fwd_rd = 5.
  - Then raise out_ready -> 0xA consumed, 0xB next cycle, then EMPTY.
- Flush in FULL with in_valid = 1: state FULL (0x1, 0x2), flush = 1 for one cycle with input 0x3 -> next cycle out_valid = 0, occupancy 0, in_ready = 1; 0x3 never appears at the output.
- x0 forwarding: accept ALUResult 0xDEAD with rd = 0 and RegWrite = 1 -> out_valid = 1, fwd_valid = 0.
- Async reset mid-stall: FULL state, assert reset between clock edges -> out_valid and occupancy drop to 0 immediately without a clock edge; in_ready = 1; after release, a new 0x55 passes with 1-cycle latency.
